// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the vertical timing state encoding.
package vga_timing_pkg;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL      = 800;

  typedef enum logic [1:0] {
    V_ST_ACTIVE = 2'd0,
    V_ST_FRONT  = 2'd1,
    V_ST_SYNC   = 2'd2,
    V_ST_BACK   = 2'd3
  } vstate_e;
endpackage

// File: rtl/vga_pulse_edge.sv
// Level-to-pulse rising-edge detector. The reset value of the history flop is a
// parameter so a level already high when reset is released can be ignored.
module vga_pulse_edge #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  output logic pulse
);
  logic lvl_q, lvl_d;

  always_comb lvl_d = lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= RST_VAL;
    else        lvl_q <= lvl_d;
  end

  assign pulse = lvl & ~lvl_q;
endmodule

// File: rtl/vga_vertical_sync.sv
// Vertical VGA timing: line counter, porch/sync FSM, vsync, v_active, frame_start.
// Optional completed-frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_vertical_sync
  import vga_timing_pkg::*;
#(
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_end,
  output logic [15:0] y_c,
  output logic        vsync,
  output logic        v_active,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (V_TOTAL > 65536) begin : g_width_chk
      $error("vga_vertical_sync: V_TOTAL exceeds 16-bit line counter");
    end
  endgenerate

  localparam logic [15:0] Y_LAST       = 16'(V_TOTAL - 1);
  localparam logic [15:0] Y_FRONT      = 16'(V_ACTIVE);
  localparam logic [15:0] Y_SYNC_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] Y_BACK_START = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic line_evt;

  vga_pulse_edge #(.RST_VAL(1'b1)) u_line_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .lvl   (line_end),
    .pulse (line_evt)
  );

  vstate_e     st_q, st_d;
  logic [15:0] y_q, y_d;
  logic        vsync_q, vsync_d;
  logic        v_active_q, v_active_d;
  logic        fs_q, fs_d;
  logic        wrap;

  always_comb begin
    st_d = st_q;
    y_d  = y_q;
    wrap = 1'b0;
    if (line_evt) begin
      wrap = (y_q == Y_LAST);
      y_d  = wrap ? 16'd0 : y_q + 16'd1;
      case (st_q)
        V_ST_ACTIVE: if (y_d == Y_FRONT)      st_d = V_ST_FRONT;
        V_ST_FRONT:  if (y_d == Y_SYNC_START) st_d = V_ST_SYNC;
        V_ST_SYNC:   if (y_d == Y_BACK_START) st_d = V_ST_BACK;
        V_ST_BACK:   if (wrap)                st_d = V_ST_ACTIVE;
        // Recovery from a corrupted state restarts the frame without a strobe.
        default: begin
          st_d = V_ST_ACTIVE;
          y_d  = 16'd0;
          wrap = 1'b0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they land with the counter.
    vsync_d    = (st_d == V_ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    v_active_d = (st_d == V_ST_ACTIVE);
    fs_d       = line_evt & wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= V_ST_ACTIVE;
      y_q        <= 16'd0;
      vsync_q    <= ~VSYNC_POL;
      v_active_q <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      st_q       <= st_d;
      y_q        <= y_d;
      vsync_q    <= vsync_d;
      v_active_q <= v_active_d;
      fs_q       <= fs_d;
    end
  end

  assign y_c         = y_q;
  assign vsync       = vsync_q;
  assign v_active    = v_active_q;
  assign frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb frame_cnt_d = frame_cnt_q + {15'd0, fs_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= 16'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif
endmodule
